// File: rtl/framebuf_arbiter_pkg.sv
// Framebuffer geometry shared by the scan-out, capture and arbitration logic.
package framebuf_arbiter_pkg;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    localparam int FB_WIDTH   = 176;
    localparam int FB_HEIGHT  = 144;
    localparam int FB_PIXELS  = frame_pixels(FB_WIDTH, FB_HEIGHT);
    localparam int ADDR_WIDTH = 16;

endpackage

// File: rtl/framebuf_arbiter_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty depend only on registered state.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = store[rd_ptr[PTR_W-1:0]];

    // Advance the pointers; reset discards every queued entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/framebuf_arbiter.sv
// Shares the single-port framebuffer BRAM between VGA scan-out (fixed priority,
// fixed two-cycle latency) and the camera writer, whose pixels queue in a FIFO
// and drain whenever the reader leaves the port idle.
module framebuf_arbiter #(
    parameter int FB_WIDTH   = framebuf_arbiter_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = framebuf_arbiter_pkg::FB_HEIGHT,
    parameter int ADDR_WIDTH = framebuf_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  vga_clk_25,
    input  logic                  reset_n,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_sof,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  frame_done,
    output logic                  overflow
);

    import framebuf_arbiter_pkg::*;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE
    } arb_state_t;

    localparam int ENTRY_W   = ADDR_WIDTH + DATA_WIDTH;
    localparam int PIX_COUNT = frame_pixels(FB_WIDTH, FB_HEIGHT);
    // One extra bit so the end-of-frame compare never wraps.
    localparam logic [ADDR_WIDTH:0]   PIX_LIMIT = (ADDR_WIDTH + 1)'(PIX_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIX_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic                  wr_xfer;
    logic                  in_frame;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // Writer handshake is based on registered FIFO state only; a same-cycle
    // pop does not open a slot.
    assign wr_ready   = reset_n & ~fifo_full;
    assign wr_xfer    = wr_valid & wr_ready;
    assign in_frame   = ({1'b0, wr_cnt} < PIX_LIMIT);
    assign fifo_push  = wr_xfer & (wr_sof | in_frame);
    assign push_addr  = wr_sof ? '0 : wr_cnt;
    assign push_entry = {push_addr, wr_data};
    assign {head_addr, head_data} = head_entry;

    // Read data is taken straight from the BRAM; only rd_valid qualifies it.
    assign rd_data = mem_rdata;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (vga_clk_25),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Raster write-address generator: restarts on sof, saturates at frame end.
    always_ff @(posedge vga_clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else if (wr_xfer) begin
            if (wr_sof) begin
                wr_cnt   <= ADDR_ONE;
                overflow <= 1'b0;
            end else if (in_frame) begin
                wr_cnt   <= wr_cnt + ADDR_ONE;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge vga_clk_25 or negedge reset_n) begin
        if (!reset_n) state <= ARB_IDLE;
        else          state <= state_nxt;
    end

    // Grant decision: reader always wins, writer drains only into idle slots.
    always_comb begin
        state_nxt = ARB_IDLE;
        fifo_pop  = 1'b0;
        if (rd_req) begin
            state_nxt = ARB_READ;
        end else if (!fifo_empty) begin
            state_nxt = ARB_WRITE;
            fifo_pop  = 1'b1;
        end
    end

    // BRAM port registers follow the grant chosen this cycle.
    always_ff @(posedge vga_clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state_nxt)
                ARB_READ: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= rd_addr;
                end
                ARB_WRITE: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= head_addr;
                    mem_wdata <= head_data;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Read-valid and end-of-frame pulses trail the granted BRAM cycle by one clock.
    always_ff @(posedge vga_clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_valid   <= (state == ARB_READ);
            frame_done <= (state == ARB_WRITE) && (mem_addr == LAST_ADDR);
        end
    end

endmodule

// File: tb/tb_framebuf_arbiter.sv
// Scoreboard bench for framebuf_arbiter with a behavioural BRAM model.
`timescale 1ns/1ps
module tb_framebuf_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int PIX = 176 * 144;

    logic          vga_clk_25 = 1'b0;
    logic          reset_n    = 1'b0;
    logic          rd_req     = 1'b0;
    logic [AW-1:0] rd_addr    = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid   = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data    = '0;
    logic          wr_sof     = 1'b0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata  = '0;
    logic          frame_done;
    logic          overflow;

    framebuf_arbiter dut (
        .vga_clk_25 (vga_clk_25),
        .reset_n    (reset_n),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_sof     (wr_sof),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #20 vga_clk_25 = ~vga_clk_25;

    logic [DW-1:0] bram [65536];

    always @(posedge vga_clk_25) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bram[mem_addr];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Scoreboard state and writer model.
    logic [AW+DW-1:0] wr_q [$];
    logic [DW-1:0]    rd_dq [$];
    int               rd_cq [$];
    int               wcyc_q [$];
    int               cyc = 0;
    int               m_cnt = 0;
    logic             m_ovf = 1'b0;
    int               n_wr = 0, n_rdv = 0, n_fd = 0, n_acc = 0;
    int               last_px_cyc = -10;
    logic [AW-1:0]    last_wr_addr = '0;

    always @(negedge vga_clk_25) begin
        cyc++;
        if (reset_n) begin
            if (mem_en && mem_we) begin
                n_wr++;
                wcyc_q.push_back(cyc);
                last_wr_addr = mem_addr;
                chk_eq("wr_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) chk_eq("wr_entry", {mem_addr, mem_wdata}, wr_q.pop_front());
                if (mem_addr == AW'(PIX - 1)) last_px_cyc = cyc;
            end
            if (rd_valid) begin
                n_rdv++;
                chk_eq("rd_expected", 32'(rd_dq.size() != 0), 1);
                if (rd_dq.size() != 0) begin
                    chk_eq("rd_data", rd_data, rd_dq.pop_front());
                    chk_eq("rd_latency", cyc, rd_cq.pop_front());
                end
            end
            if (frame_done) begin
                n_fd++;
                chk_eq("fd_timing", cyc, last_px_cyc + 1);
            end
            if (wr_valid && wr_ready) begin
                n_acc++;
                if (wr_sof) begin
                    wr_q.push_back({{AW{1'b0}}, wr_data});
                    m_cnt = 1;
                    m_ovf = 1'b0;
                end else if (m_cnt < PIX) begin
                    wr_q.push_back({AW'(m_cnt), wr_data});
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (rd_req) begin
                rd_dq.push_back(pat(rd_addr));
                rd_cq.push_back(cyc + 2);
            end
        end
    end

    task automatic tick();
        @(posedge vga_clk_25);
        #1;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        rd_req   = 1'b0;
        repeat (n) tick();
    endtask

    // Offer one pixel and hold it until accepted; wr_valid stays high afterwards.
    task automatic send_pix(input logic [DW-1:0] d, input logic sof);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_sof   = sof;
        while (!acc && n < 100) begin
            @(negedge vga_clk_25);
            acc = wr_ready;
            tick();
            n++;
        end
        if (!acc) chk_eq("send_accept", 32'(acc), 1);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int t0, acc0, rdv0, wr0, fd0;

    initial begin
        for (int i = 0; i < 65536; i++) bram[i] = pat(AW'(i));

        // Reset state
        repeat (3) tick();
        chk_eq("rst_wr_ready", wr_ready, 0);
        chk_eq("rst_ctrl", {mem_en, mem_we, rd_valid, frame_done, overflow}, 0);
        chk_eq("rst_addr_data", {mem_addr, mem_wdata}, 0);
        reset_n = 1'b1;
        tick();
        tick();
        chk_eq("ready_after_rst", wr_ready, 1);

        // 1: four pixels, no reads
        wcyc_q.delete();
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'h10 + i);
            wr_sof   = 1'b0;
            chk_eq("t1_ready_high", wr_ready, 1);
            tick();
        end
        idle(6);
        chk_eq("t1_ready_high_end", wr_ready, 1);
        chk_eq("t1_write_count", wcyc_q.size(), 4);
        for (int i = 0; i < 4 && i < wcyc_q.size(); i++)
            chk_eq("t1_write_cycle", wcyc_q[i], t0 + 2 + i);

        // 2: read burst while the writer streams
        wcyc_q.delete();
        acc0 = n_acc;
        rdv0 = n_rdv;
        t0   = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rd_req   = 1'b1;
            rd_addr  = AW'(100 + i);
            wr_valid = 1'b1;
            wr_data  = DW'(8'hA0 + i);
            wr_sof   = 1'b0;
            tick();
        end
        chk_eq("t2_accepts", n_acc - acc0, 4);
        chk_eq("t2_ready_low_full", wr_ready, 0);
        idle(8);
        chk_eq("t2_read_count", n_rdv - rdv0, 10);
        chk_eq("t2_drain_count", wcyc_q.size(), 4);
        if (wcyc_q.size() != 0) chk_eq("t2_drain_start", wcyc_q[0], t0 + 11);

        // 3: one full frame
        fd0 = n_fd;
        for (int i = 0; i < PIX; i++) send_pix(DW'(i * 7), (i == 0));
        idle(6);
        chk_eq("t3_frame_done_count", n_fd - fd0, 1);
        chk_eq("t3_last_addr", last_wr_addr, PIX - 1);
        chk_eq("t3_overflow", overflow, m_ovf);
        chk_eq("t3_queue_empty", wr_q.size(), 0);

        // 4: pixel beyond the frame end, then a new frame
        wr0 = n_wr;
        send_pix(8'hEE, 1'b0);
        idle(5);
        chk_eq("t4_no_write", n_wr - wr0, 0);
        chk_eq("t4_overflow_set", overflow, 1);
        send_pix(8'h11, 1'b1);
        idle(5);
        chk_eq("t4_sof_write", n_wr - wr0, 1);
        chk_eq("t4_sof_addr", last_wr_addr, 0);
        chk_eq("t4_overflow_clr", overflow, 0);

        // 5: reset with a read in flight and three queued pixels
        rd_req  = 1'b1;
        rd_addr = AW'(40000);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'h70 + i);
            wr_sof   = 1'b0;
            tick();
        end
        wr_valid = 1'b0;
        tick();
        chk_eq("t5_pre_rst_mem_en", mem_en, 1);
        reset_n = 1'b0;
        wr_q.delete();
        rd_dq.delete();
        rd_cq.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        #1;
        chk_eq("t5_rst_mem_en", {mem_en, mem_we}, 0);
        chk_eq("t5_rst_rd_valid", rd_valid, 0);
        chk_eq("t5_rst_wr_ready", wr_ready, 0);
        rd_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wr0  = n_wr;
        rdv0 = n_rdv;
        idle(10);
        chk_eq("t5_no_writes", n_wr - wr0, 0);
        chk_eq("t5_no_rd_valid", n_rdv - rdv0, 0);
        chk_eq("t5_ready_after", wr_ready, 1);

        // 6: sof mid-frame with entries still queued
        for (int i = 0; i < 498; i++) send_pix(DW'(i + 3), (i == 0));
        idle(4);
        wr0     = n_wr;
        rd_req  = 1'b1;
        rd_addr = AW'(50000);
        send_pix(8'hC1, 1'b0);
        send_pix(8'hC2, 1'b0);
        send_pix(8'hC3, 1'b1);
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        tick();
        tick();
        chk_eq("t6_held_by_reads", n_wr - wr0, 0);
        idle(8);
        chk_eq("t6_write_count", n_wr - wr0, 3);
        chk_eq("t6_sof_last_addr", last_wr_addr, 0);
        chk_eq("t6_overflow", overflow, m_ovf);
        chk_eq("t6_queue_empty", wr_q.size() + rd_dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuf_arbiter.md
Name: framebuf_arbiter

Overview:
Shares the single-port framebuffer BRAM between the VGA scan-out reader and the camera pixel writer. The reader has fixed priority and a guaranteed fixed read latency. Writer pixels are buffered in a small FIFO and drained into BRAM whenever the reader leaves the port idle. A write-address generator maps the raster-order pixel stream onto framebuffer addresses and resets at start-of-frame.

Parameters:
FB_WIDTH, 176, framebuffer width in pixels
FB_HEIGHT, 144, framebuffer height in pixels
ADDR_WIDTH, 16, BRAM address width; must satisfy 2^ADDR_WIDTH >= FB_WIDTH*FB_HEIGHT
DATA_WIDTH, 8, pixel width
FIFO_DEPTH, 4, write-FIFO entries; power of two, >= 2

Ports:
vga_clk_25  in  1  pixel clock; only clock in the block
reset_n  in  1  asynchronous active-low reset
rd_req  in  1  reader requests one pixel this cycle
rd_addr  in  ADDR_WIDTH  reader address, sampled with rd_req
rd_data  out  DATA_WIDTH  read pixel; valid when rd_valid=1
rd_valid  out  1  read data qualifier
wr_valid  in  1  writer pixel valid
wr_ready  out  1  writer may transfer (transfer = wr_valid & wr_ready)
wr_data  in  DATA_WIDTH  writer pixel
wr_sof  in  1  qualifies wr_valid: this pixel is the first of a frame
mem_en  out  1  BRAM port enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_WIDTH  BRAM address
mem_wdata  out  DATA_WIDTH  BRAM write data
mem_rdata  in  DATA_WIDTH  BRAM read data, one cycle after mem_en & !mem_we
frame_done  out  1  one-cycle pulse when pixel FB_WIDTH*FB_HEIGHT-1 is written to BRAM
overflow  out  1  sticky: a pixel beyond the frame end was dropped; cleared by an accepted sof pixel

Behaviour:
- Reset (async assert, sync deassert): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, frame_done=0, overflow=0, FIFO empty, write counter=0, wr_ready=0 while reset_n=0. In-flight reads are discarded, so no rd_valid follows reset.
- wr_ready = !fifo_full, registered-state based. A pop in the same cycle does not raise wr_ready.
- Write address generator, on each transfer:
  - If wr_sof: entry addr=0, counter<=1, overflow<=0.
  - Else if counter < FB_WIDTH*FB_HEIGHT: entry addr=counter, counter<=counter+1.
  - Else: pixel is consumed but not pushed, and overflow<=1. The counter saturates.
- FIFO entry = {addr, data}. Push on a transfer that is not dropped.
- Arbiter FSM, registered grant per cycle. States are IDLE, READ, WRITE; the next state is evaluated every cycle:
  - rd_req=1 -> READ: mem_en=1, mem_we=0, mem_addr=rd_addr (one cycle later).
  - else FIFO non-empty -> WRITE: pop head; mem_en=1, mem_we=1, mem_addr/mem_wdata=head (one cycle later).
  - else -> IDLE: mem_en=0, mem_we=0.
  - Read always wins a simultaneous request; the writer waits with no starvation timer. Reads use at most FB_WIDTH of every 800 clocks.
- Read latency: rd_req at cycle N -> mem_en at N+1 -> rd_valid=1 and rd_data=mem_rdata at N+2. Back-to-back requests are fully pipelined at one per cycle.
- rd_data is a combinational pass-through of mem_rdata and is undefined when rd_valid=0.
- frame_done is registered and asserts the cycle after the write-grant cycle that carries addr FB_WIDTH*FB_HEIGHT-1.
- Width rule: the counter is ADDR_WIDTH bits; the compare against FB_WIDTH*FB_HEIGHT uses ADDR_WIDTH+1 bits to avoid wrap.
- sof mid-frame restarts addressing at 0. Entries already in the FIFO keep their old addresses and are still written.

Decomposition:
- Shared package holds FB_WIDTH, FB_HEIGHT, FB_PIXELS and ADDR_WIDTH constants, also consumed by vga_controller and the capture block.
- Arbiter state encoding constants are local to the block.
- One sub-module: sync_fifo, parameterised by width and depth, with push/pop/full/empty. It is reusable elsewhere in the codebase.

Test Plan:
1. Reset, then push 4 pixels with rd_req=0 -> four writes at mem_addr 0..3 on consecutive cycles starting 2 cycles after the first transfer; wr_ready stays 1.
2. rd_req held for 10 cycles, addresses 100..109, while the writer streams -> rd_valid for exactly 10 cycles, starting 2 cycles after the first request, carrying BRAM[100..109]. wr_ready drops after 4 accepts; queued writes drain immediately after the read burst.
3. Stream 25344 pixels with sof on the first -> last write at addr 25343, frame_done pulses once, overflow=0.
4. Send a 25345th pixel without sof -> no BRAM write, overflow=1. The next sof pixel writes addr 0 and clears overflow.
5. Assert reset_n=0 while a read is in flight and the FIFO holds 3 entries -> mem_en=0 immediately, no rd_valid, and no pending writes occur after release.
6. sof mid-frame at counter=500 with 2 entries queued -> queued entries are written at their old addresses, then the sof pixel at addr 0.
